mem_fill_seq: RTL and testbench

//  Parametrised successor to the fixed 64x2-bit clear sequencer. Drives the SPI memory command port to

---
 rtl/mem_fill_seq.sv | 125 ++++++++++++
 tb/tb_mem_fill_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_seq.sv
// mem_fill_seq: fills a run-time address range over the SPI memory command port, with optional read-back verify
// clk, rst_n (synchronous, active low); en run request (level, low aborts)
// start_addr/end_addr/fill_value/pattern_sel/verify_en: run config, sampled on run start
// mem_cmd/mem_en/mem_addr/mem_wdata: command out; mem_valid/mem_rdata: completion in
// busy/done/error/err_addr: run status
module mem_fill_seq #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 2,
  parameter int WREN_EVERY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic [DATA_W-1:0] fill_value,
  input  logic              pattern_sel,
  input  logic              verify_en,
  output logic [1:0]        mem_cmd,
  output logic              mem_en,
  input  logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);
  localparam logic [1:0] CMD_WREN = 2'd1, CMD_WRITE = 2'd2, CMD_READ = 2'd3;
  typedef enum logic [1:0] {IDLE, WREN, WRITE, READ} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] start_l, end_l, addr_n, err_addr_n;
  logic [DATA_W-1:0] fill_l;
  logic sel_l, verify_l, en_n, done_n, error_n, load, cpl, last;
  assign cpl = mem_en && mem_valid;
  assign last = mem_addr == end_l;
  assign mem_wdata = sel_l ? DATA_W'(mem_addr) : fill_l;
  assign busy = state != IDLE;
  assign mem_cmd = state == WREN ? CMD_WREN : state == WRITE ? CMD_WRITE : state == READ ? CMD_READ : 2'd0;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      mem_en <= 1'b0;
      mem_addr <= '0;
      done <= 1'b0;
      error <= 1'b0;
      err_addr <= '0;
      start_l <= '0;
      end_l <= '0;
      fill_l <= '0;
      sel_l <= 1'b0;
      verify_l <= 1'b0;
    end else begin
      state <= state_n;
      mem_en <= en_n;
      mem_addr <= addr_n;
      done <= done_n;
      error <= error_n;
      err_addr <= err_addr_n;
      if (load) begin
        start_l <= start_addr;
        end_l <= end_addr;
        fill_l <= fill_value;
        sel_l <= pattern_sel;
        verify_l <= verify_en;
      end
    end
  always_comb begin
    state_n = state;
    en_n = mem_en;
    addr_n = mem_addr;
    done_n = done;
    error_n = error;
    err_addr_n = err_addr;
    load = 1'b0;
    case (state)
      IDLE:
        if (!en) done_n = 1'b0;
        else if (!done) begin
          load = 1'b1;
          addr_n = start_addr;
          error_n = 1'b0;
          en_n = 1'b1;
          state_n = WREN;
        end
      WREN: if (cpl) state_n = WRITE;
      WRITE:
        if (cpl) begin
          if (last) begin
            addr_n = start_l;
            state_n = verify_l ? READ : IDLE;
            done_n = !verify_l;
          end else begin
            addr_n = mem_addr + 1'b1;
            if (WREN_EVERY != 0) state_n = WREN;
          end
        end
      READ:
        if (cpl) begin
          if (mem_rdata != mem_wdata) begin
            error_n = 1'b1;
            err_addr_n = mem_addr;
            state_n = IDLE;
            done_n = 1'b1;
          end else if (last) begin
            state_n = IDLE;
            done_n = 1'b1;
          end else addr_n = mem_addr + 1'b1;
        end
      default: state_n = IDLE;
    endcase
    // request handshake: drop after completion, re-raise only once mem_valid has fallen
    if (state != IDLE) begin
      if (cpl) en_n = 1'b0;
      else if (!mem_en && en && !mem_valid) en_n = 1'b1;
      // abort waits for any in-flight transaction before leaving
      if (!en && (cpl || !mem_en)) begin
        state_n = IDLE;
        done_n = 1'b0;
        en_n = 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_fill_seq.sv
// tb_mem_fill_seq: random and directed runs of mem_fill_seq (WREN_EVERY 0 and 1) against a transaction-list model
module tb_mem_fill_seq;
  localparam logic [1:0] C_WREN = 2'd1, C_WRITE = 2'd2, C_READ = 2'd3;
  typedef struct packed {logic [1:0] c; logic [5:0] a; logic [1:0] d;} txn_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [5:0] start_addr = '0, end_addr = '0;
  logic [1:0] fill_value = '0;
  logic pattern_sel = 1'b0, verify_en = 1'b0;
  int checks = 0, errors = 0;
  int bad_addr = -1, dmin = 1, dmax = 1;
  bit abort_mode = 1'b0;
  txn_t tmp_q[$];
  always #5 clk = ~clk;
  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    logic [1:0] cmd, wdata, rdata = '0;
    logic men, mval = 1'b0, bsy, dn, er, kill = 1'b0, en_i;
    logic [5:0] maddr, eaddr;
    logic [1:0] mem [64];
    txn_t exp_q[$];
    txn_t hold, e;
    int rises = 0, cnt = 0, need = 1;
    bit was_en = 1'b0;
    assign en_i = en && !kill;
    mem_fill_seq #(.ADDR_W(6), .DATA_W(2), .WREN_EVERY(g)) dut (
      .clk(clk), .rst_n(rst_n), .en(en_i), .start_addr(start_addr), .end_addr(end_addr),
      .fill_value(fill_value), .pattern_sel(pattern_sel), .verify_en(verify_en),
      .mem_cmd(cmd), .mem_en(men), .mem_valid(mval), .mem_addr(maddr), .mem_wdata(wdata),
      .mem_rdata(rdata), .busy(bsy), .done(dn), .error(er), .err_addr(eaddr));
    initial begin
      foreach (mem[i]) mem[i] = 2'd0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          mval = 1'b0;
          cnt = 0;
        end else if (mval) mval = 1'b0;
        else if (men) begin
          if (!was_en) begin
            rises++;
            hold = {cmd, maddr, wdata};
            if (exp_q.size() == 0) chk($sformatf("u%0d extra txn at addr %0d", g, maddr), 1, 0);
            else begin
              e = exp_q.pop_front();
              chk($sformatf("u%0d cmd", g), cmd, e.c);
              chk($sformatf("u%0d addr", g), maddr, e.a);
              if (e.c == C_WRITE) chk($sformatf("u%0d wdata@%0d", g, maddr), wdata, e.d);
            end
            if (cmd == C_WRITE) mem[maddr] = wdata;
            rdata = mem[maddr] ^ ((int'(maddr) == bad_addr) ? 2'd1 : 2'd0);
            if (abort_mode && cmd == C_WRITE && maddr == 6'd10) kill = 1'b1;
            need = $urandom_range(dmax, dmin);
            cnt = 0;
          end else chk($sformatf("u%0d stable cmd/addr/wdata", g), {cmd, maddr, wdata}, hold);
          chk($sformatf("u%0d busy with mem_en", g), bsy, 1);
          cnt++;
          if (cnt >= need) mval = 1'b1;
        end
        was_en = men;
      end
    end
  end
  task automatic build(input int wrev, input logic [5:0] s, e, input logic [1:0] f, input bit sel, ver);
    int n;
    logic [5:0] a;
    n = ((int'(e) - int'(s)) & 63) + 1;
    tmp_q.delete();
    tmp_q.push_back({C_WREN, s, 2'd0});
    for (int i = 0; i < n; i++) begin
      a = 6'(int'(s) + i);
      if (wrev != 0 && i > 0) tmp_q.push_back({C_WREN, a, 2'd0});
      tmp_q.push_back({C_WRITE, a, sel ? a[1:0] : f});
      if (abort_mode && a == 6'd10) return;
    end
    for (int i = 0; ver && i < n; i++) begin
      a = 6'(int'(s) + i);
      tmp_q.push_back({C_READ, a, 2'd0});
      if (int'(a) == bad_addr) break;
    end
  endtask
  task automatic load_model(input logic [5:0] s, e, input logic [1:0] f, input bit sel, ver);
    build(0, s, e, f, sel, ver);
    u[0].exp_q = tmp_q;
    build(1, s, e, f, sel, ver);
    u[1].exp_q = tmp_q;
    u[0].rises = 0;
    u[1].rises = 0;
  endtask
  task automatic rchk(string tag, logic men, dn, er, bsy, logic [5:0] ma, ea);
    chk({tag, " reset mem_en"}, men, 0);
    chk({tag, " reset done"}, dn, 0);
    chk({tag, " reset error"}, er, 0);
    chk({tag, " reset busy"}, bsy, 0);
    chk({tag, " reset mem_addr"}, ma, 0);
    chk({tag, " reset err_addr"}, ea, 0);
  endtask
  task automatic fin(string tag, bit ab, exp_err, int bad, logic dn, er, bsy, logic [5:0] ea, int qs);
    chk({tag, " done"}, dn, ab ? 0 : 1);
    chk({tag, " error"}, er, exp_err);
    if (exp_err) chk({tag, " err_addr"}, ea, bad);
    chk({tag, " missing txns"}, qs, 0);
    chk({tag, " busy at end"}, bsy, 0);
  endtask
  task automatic run(input logic [5:0] s, e, input logic [1:0] f, input bit sel, ver,
                     input int bad, lo, hi, input bit ab, input int rst_at);
    int n, t;
    bit exp_err;
    n = ((int'(e) - int'(s)) & 63) + 1;
    exp_err = ver && bad >= 0 && (((bad - int'(s)) & 63) < n);
    start_addr = s;
    end_addr = e;
    fill_value = f;
    pattern_sel = sel;
    verify_en = ver;
    bad_addr = bad;
    dmin = lo;
    dmax = hi;
    abort_mode = ab;
    load_model(s, e, f, sel, ver);
    en = 1'b1;
    @(negedge clk);
    chk("u0 start latency", u[0].men, 1);
    chk("u1 start latency", u[1].men, 1);
    t = 0;
    while (!(ab ? (u[0].kill && u[1].kill && !u[0].bsy && !u[1].bsy) : (u[0].dn && u[1].dn)) && t < 20000) begin
      if (rst_at >= 0 && u[0].men && u[0].cmd == C_READ && int'(u[0].maddr) == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rchk("u0 mid-run", u[0].men, u[0].dn, u[0].er, u[0].bsy, u[0].maddr, u[0].eaddr);
        rchk("u1 mid-run", u[1].men, u[1].dn, u[1].er, u[1].bsy, u[1].maddr, u[1].eaddr);
        load_model(s, e, f, sel, ver);
        rst_n = 1'b1;
        rst_at = -1;
      end
      @(negedge clk);
      t++;
    end
    chk("run completes within bound", t < 20000 ? 1 : 0, 1);
    repeat (5) @(negedge clk);
    fin("u0", ab, exp_err, bad, u[0].dn, u[0].er, u[0].bsy, u[0].eaddr, u[0].exp_q.size());
    fin("u1", ab, exp_err, bad, u[1].dn, u[1].er, u[1].bsy, u[1].eaddr, u[1].exp_q.size());
    en = 1'b0;
    u[0].kill = 1'b0;
    u[1].kill = 1'b0;
    abort_mode = 1'b0;
    @(negedge clk);
    chk("u0 done cleared after en low", u[0].dn, 0);
    chk("u1 done cleared after en low", u[1].dn, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rchk("u0 initial", u[0].men, u[0].dn, u[0].er, u[0].bsy, u[0].maddr, u[0].eaddr);
    rchk("u1 initial", u[1].men, u[1].dn, u[1].er, u[1].bsy, u[1].maddr, u[1].eaddr);
    rst_n = 1'b1;
    @(negedge clk);
    run(6'd0, 6'd63, 2'd0, 1'b0, 1'b0, -1, 1, 1, 1'b0, -1);
    chk("full fill u0 txn count", u[0].rises, 65);
    chk("full fill u1 txn count", u[1].rises, 128);
    run(6'd60, 6'd3, 2'($urandom), 1'b1, 1'b0, -1, 1, 2, 1'b0, -1);
    chk("wrap fill u0 txn count", u[0].rises, 9);
    chk("wrap fill u1 txn count", u[1].rises, 16);
    run(6'd0, 6'd63, 2'($urandom), 1'b0, 1'b1, 5, 1, 1, 1'b0, -1);
    chk("verify u0 error", u[0].er, 1);
    chk("verify u0 err_addr", u[0].eaddr, 5);
    chk("verify u0 txn count", u[0].rises, 71);
    run(6'd9, 6'd9, 2'($urandom), 1'($urandom), 1'b0, -1, 1, 3, 1'b0, -1);
    chk("single word u1 txn count", u[1].rises, 2);
    chk("single word u0 txn count", u[0].rises, 2);
    run(6'd0, 6'd63, 2'd1, 1'b0, 1'b0, -1, 4, 4, 1'b1, -1);
    chk("abort u0 txn count", u[0].rises, 12);
    chk("abort u1 txn count", u[1].rises, 22);
    chk("abort u0 error", u[0].er, 0);
    run(6'd0, 6'd63, 2'd2, 1'b1, 1'b1, -1, 1, 2, 1'b0, 3);
    chk("restart u0 txn count", u[0].rises, 129);
    for (int k = 0; k < 10; k++)
      run(6'($urandom), 6'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(1, 0) != 0) ? int'($urandom_range(63, 0)) : -1, 1, 3, 1'b0, -1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
